// File: rtl/regfile_sb_if.sv
// Register-file bus between the decode/control FSM and the register file.
//   Write port    : we3, wa3, wd3
//   Read ports    : ra1/ra2/ra3 in; rd1/rd2/rd3 out; r15 supplies the PC+8 value
//   Scoreboard    : sb_set, sb_wa in; busy1/busy2/busy3 out
//   Status        : ready (clear sequence finished)
// Modports:
//   master - the controller side, which drives addresses, write data and scoreboard marks
//   slave  - the register file itself
interface regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic              we3;
    logic [ADDR_W-1:0] wa3;
    logic [DATA_W-1:0] wd3;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [ADDR_W-1:0] ra3;
    logic [DATA_W-1:0] r15;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] rd3;
    logic              sb_set;
    logic [ADDR_W-1:0] sb_wa;
    logic              busy1;
    logic              busy2;
    logic              busy3;
    logic              ready;

    modport master (
        output we3, wa3, wd3, ra1, ra2, ra3, r15, sb_set, sb_wa,
        input  rd1, rd2, rd3, busy1, busy2, busy3, ready
    );

    modport slave (
        input  we3, wa3, wd3, ra1, ra2, ra3, r15, sb_set, sb_wa,
        output rd1, rd2, rd3, busy1, busy2, busy3, ready
    );
endinterface

// File: rtl/regfile_sb.sv
// Architectural register file for the multicycle ARM datapath.
// Three combinational read ports, one synchronous write port, a PC override
// index (reads return bus.r15, writes are dropped), a hardware clear sequence
// after reset, optional write-to-read bypass, and a per-register pending
// scoreboard for multicycle results still in flight.
// Ports:
//   clk   - clock, all state updates on the rising edge
//   reset - synchronous, active-high; restarts the clear sequence
//   bus   - regfile_sb_if.slave: write port, three read ports, r15,
//           scoreboard set, busy flags and ready
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int PC_IDX = (1 << ADDR_W) - 1,
    parameter int BYPASS = 1
) (
    input  logic         clk,
    input  logic         reset,
    regfile_sb_if.slave  bus
);
    localparam int NREGS = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] PC_A     = ADDR_W'(PC_IDX);
    localparam logic [ADDR_W-1:0] LAST_CLR = ADDR_W'(PC_IDX - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] clr_cnt_reg, clr_cnt_next;
    logic              run;

    assign run       = (state_reg == ST_RUN);
    assign bus.ready = run;

    // ------------------------------------------------------------------
    // Clear / run control
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_CLEAR;
            clr_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_cnt_reg <= clr_cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        clr_cnt_next = clr_cnt_reg;
        case (state_reg)
            ST_CLEAR: begin
                // Counter stops on the last storage index instead of wrapping.
                if (clr_cnt_reg == LAST_CLR) begin
                    state_next = ST_RUN;
                end else begin
                    clr_cnt_next = clr_cnt_reg + 1'b1;
                end
            end
            ST_RUN: begin
                state_next = ST_RUN;
            end
            default: begin
                state_next   = ST_CLEAR;
                clr_cnt_next = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Storage. The PC index is never written and never read (reads of it
    // return bus.r15), so its entry is dead and is trimmed away.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] rf [NREGS];
    logic              wr_en;

    assign wr_en = run & bus.we3 & (bus.wa3 != PC_A);

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (!run) begin
                rf[clr_cnt_reg] <= '0;
            end else if (wr_en) begin
                rf[bus.wa3] <= bus.wd3;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pending scoreboard: a write retires the pending mark, a new issue
    // sets it; when both target the same register the new issue wins.
    // ------------------------------------------------------------------
    logic [NREGS-1:0] pend_reg, pend_next;

    for (genvar gi = 0; gi < NREGS; gi++) begin : g_pend
        localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);
        if (gi == PC_IDX) begin : g_pc
            assign pend_next[gi] = 1'b0;
        end else begin : g_reg
            logic hit_set;
            logic hit_wr;
            assign hit_set       = bus.sb_set & (bus.sb_wa == IDX);
            assign hit_wr        = bus.we3 & (bus.wa3 == IDX);
            assign pend_next[gi] = run ? (hit_set | (pend_reg[gi] & ~hit_wr))
                                       : pend_reg[gi];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_reg <= '0;
        end else begin
            pend_reg <= pend_next;
        end
    end

    // ------------------------------------------------------------------
    // Read ports. All outputs are held at zero until the clear finishes.
    // A bypassed read is never busy: the value it needs is on wd3 now.
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] ra [3];

    assign ra[0] = bus.ra1;
    assign ra[1] = bus.ra2;
    assign ra[2] = bus.ra3;

    for (genvar gi = 0; gi < 3; gi++) begin : g_port
        logic [DATA_W-1:0] data;
        logic              bsy;

        always_comb begin
            data = '0;
            bsy  = 1'b0;
            if (run) begin
                if (ra[gi] == PC_A) begin
                    data = bus.r15;
                end else if ((BYPASS != 0) && bus.we3 && (bus.wa3 == ra[gi])) begin
                    data = bus.wd3;
                end else begin
                    data = rf[ra[gi]];
                    bsy  = pend_reg[ra[gi]];
                end
            end
        end
    end

    assign bus.rd1   = g_port[0].data;
    assign bus.rd2   = g_port[1].data;
    assign bus.rd3   = g_port[2].data;
    assign bus.busy1 = g_port[0].bsy;
    assign bus.busy2 = g_port[1].bsy;
    assign bus.busy3 = g_port[2].bsy;

endmodule

// File: tb/tb_regfile_sb.sv
// Testbench for regfile_sb. Two instances share one stimulus stream: dut
// (BYPASS=1) is checked in full, dut_nb (BYPASS=0) is checked on read port 1,
// busy1 and ready. Inputs change on the falling edge and outputs are
// sampled 1 time unit later.
module tb_regfile_sb;
    logic clk;
    logic reset;

    regfile_sb_if #(.DATA_W(32), .ADDR_W(4)) bus ();
    regfile_sb_if #(.DATA_W(32), .ADDR_W(4)) bus_nb ();

    regfile_sb #(.DATA_W(32), .ADDR_W(4), .PC_IDX(15), .BYPASS(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    regfile_sb #(.DATA_W(32), .ADDR_W(4), .PC_IDX(15), .BYPASS(0)) dut_nb (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_nb)
    );

    assign bus_nb.we3    = bus.we3;
    assign bus_nb.wa3    = bus.wa3;
    assign bus_nb.wd3    = bus.wd3;
    assign bus_nb.ra1    = bus.ra1;
    assign bus_nb.ra2    = bus.ra2;
    assign bus_nb.ra3    = bus.ra3;
    assign bus_nb.r15    = bus.r15;
    assign bus_nb.sb_set = bus.sb_set;
    assign bus_nb.sb_wa  = bus.sb_wa;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        we3;
        logic [3:0]  wa3;
        logic [31:0] wd3;
        logic [3:0]  ra1;
        logic [3:0]  ra2;
        logic [3:0]  ra3;
        logic [31:0] r15;
        logic        sb_set;
        logic [3:0]  sb_wa;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic [31:0] e_rd3;
        logic [2:0]  e_busy;    // {busy1, busy2, busy3}
        logic [31:0] e_nb_rd1;
        logic        e_nb_busy1;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.we3    = 1'b0;
        bus.wa3    = '0;
        bus.wd3    = '0;
        bus.ra1    = '0;
        bus.ra2    = '0;
        bus.ra3    = '0;
        bus.r15    = '0;
        bus.sb_set = 1'b0;
        bus.sb_wa  = '0;
    endtask

    // Called at a falling edge right after the reset cycle. Drives writes and
    // scoreboard marks into already-cleared entries throughout the clear, checks
    // the outputs stay zero for exactly 15 cycles, then that ready rises.
    task automatic clear_check(input string tag);
        for (int i = 0; i < 15; i++) begin
            bus.we3    = 1'b1;
            bus.wa3    = (i == 0) ? 4'd0 : 4'(i - 1);
            bus.wd3    = 32'hA5A5_0000 + 32'(i);
            bus.sb_set = 1'b1;
            bus.sb_wa  = 4'(i);
            bus.ra1    = 4'(i);
            bus.ra2    = (i == 0) ? 4'd0 : 4'(i - 1);
            bus.ra3    = 4'd15;
            bus.r15    = 32'h0000_1111;
            #1;
            chk($sformatf("%s_ready_c%0d", tag, i), 32'(bus.ready), 32'd0);
            chk($sformatf("%s_nb_ready_c%0d", tag, i), 32'(bus_nb.ready), 32'd0);
            chk($sformatf("%s_rd_c%0d", tag, i), bus.rd1 | bus.rd2 | bus.rd3, 32'd0);
            chk($sformatf("%s_busy_c%0d", tag, i), 32'({bus.busy1, bus.busy2, bus.busy3}), 32'd0);
            $display("%s clear cycle %0d: ready=%0d rd1=%h rd2=%h rd3=%h", tag, i,
                     bus.ready, bus.rd1, bus.rd2, bus.rd3);
            @(negedge clk);
        end
        idle_inputs();
        #1;
        chk($sformatf("%s_ready_after", tag), 32'(bus.ready), 32'd1);
        chk($sformatf("%s_nb_ready_after", tag), 32'(bus_nb.ready), 32'd1);
        $display("%s clear done: ready=%0d nb_ready=%0d", tag, bus.ready, bus_nb.ready);
    endtask

    // Reads r0..r14 on all ports; every entry must be 0 and not pending.
    task automatic readback_zero(input string tag);
        for (int i = 0; i < 15; i++) begin
            bus.ra1 = 4'(i);
            bus.ra2 = 4'(i);
            bus.ra3 = 4'(i);
            #1;
            chk($sformatf("%s_r%0d", tag, i), bus.rd1 | bus.rd2 | bus.rd3 | bus_nb.rd1, 32'd0);
            chk($sformatf("%s_busy_r%0d", tag, i),
                32'({bus.busy1, bus.busy2, bus.busy3, bus_nb.busy1}), 32'd0);
            $display("%s read r%0d: rd1=%h busy=%b", tag, i, bus.rd1,
                     {bus.busy1, bus.busy2, bus.busy3});
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //           we3  wa3    wd3           ra1    ra2    ra3    r15           set   sb_wa  rd1           rd2           rd3           busy    nb_rd1        nb_b1
        vecs[0]  = '{1'b1, 4'd3,  32'hDEADBEEF, 4'd3,  4'd0,  4'd3,  32'h0,        1'b0, 4'd0,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 3'b000, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 4'd0,  32'h0,        4'd3,  4'd15, 4'd0,  32'h108,      1'b0, 4'd0,  32'hDEADBEEF, 32'h108,      32'h0,        3'b000, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 4'd15, 32'h5,        4'd15, 4'd15, 4'd3,  32'h108,      1'b0, 4'd0,  32'h108,      32'h108,      32'hDEADBEEF, 3'b000, 32'h108,      1'b0};
        vecs[3]  = '{1'b0, 4'd0,  32'h0,        4'd15, 4'd14, 4'd0,  32'h10C,      1'b0, 4'd0,  32'h10C,      32'h0,        32'h0,        3'b000, 32'h10C,      1'b0};
        vecs[4]  = '{1'b0, 4'd0,  32'h0,        4'd5,  4'd5,  4'd5,  32'h0,        1'b1, 4'd5,  32'h0,        32'h0,        32'h0,        3'b000, 32'h0,        1'b0};
        vecs[5]  = '{1'b0, 4'd0,  32'h0,        4'd5,  4'd4,  4'd5,  32'h0,        1'b0, 4'd0,  32'h0,        32'h0,        32'h0,        3'b101, 32'h0,        1'b1};
        vecs[6]  = '{1'b1, 4'd5,  32'h77,       4'd5,  4'd6,  4'd5,  32'h0,        1'b0, 4'd0,  32'h77,       32'h0,        32'h77,       3'b000, 32'h0,        1'b1};
        vecs[7]  = '{1'b0, 4'd0,  32'h0,        4'd5,  4'd6,  4'd5,  32'h0,        1'b0, 4'd0,  32'h77,       32'h0,        32'h77,       3'b000, 32'h77,       1'b0};
        vecs[8]  = '{1'b1, 4'd5,  32'h88,       4'd5,  4'd5,  4'd5,  32'h0,        1'b1, 4'd5,  32'h88,       32'h88,       32'h88,       3'b000, 32'h77,       1'b0};
        vecs[9]  = '{1'b0, 4'd0,  32'h0,        4'd5,  4'd5,  4'd5,  32'h0,        1'b0, 4'd0,  32'h88,       32'h88,       32'h88,       3'b111, 32'h88,       1'b1};
        vecs[10] = '{1'b1, 4'd5,  32'h99,       4'd5,  4'd15, 4'd5,  32'h200,      1'b1, 4'd15, 32'h99,       32'h200,      32'h99,       3'b000, 32'h88,       1'b1};
        vecs[11] = '{1'b0, 4'd0,  32'h0,        4'd5,  4'd15, 4'd5,  32'h204,      1'b0, 4'd0,  32'h99,       32'h204,      32'h99,       3'b000, 32'h99,       1'b0};
        vecs[12] = '{1'b1, 4'd2,  32'h1234,     4'd2,  4'd3,  4'd14, 32'h0,        1'b0, 4'd0,  32'h1234,     32'hDEADBEEF, 32'h0,        3'b000, 32'h0,        1'b0};

        // Power-up reset, then clear with writes and scoreboard marks that must be ignored.
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        clear_check("t1");
        @(negedge clk);
        readback_zero("t1");

        // Directed vectors: bypass, PC override, scoreboard set/clear/priority.
        for (int k = 0; k < NVEC; k++) begin
            bus.we3    = vecs[k].we3;
            bus.wa3    = vecs[k].wa3;
            bus.wd3    = vecs[k].wd3;
            bus.ra1    = vecs[k].ra1;
            bus.ra2    = vecs[k].ra2;
            bus.ra3    = vecs[k].ra3;
            bus.r15    = vecs[k].r15;
            bus.sb_set = vecs[k].sb_set;
            bus.sb_wa  = vecs[k].sb_wa;
            #1;
            chk($sformatf("v%0d_rd1", k), bus.rd1, vecs[k].e_rd1);
            chk($sformatf("v%0d_rd2", k), bus.rd2, vecs[k].e_rd2);
            chk($sformatf("v%0d_rd3", k), bus.rd3, vecs[k].e_rd3);
            chk($sformatf("v%0d_busy", k), 32'({bus.busy1, bus.busy2, bus.busy3}),
                32'(vecs[k].e_busy));
            chk($sformatf("v%0d_nb_rd1", k), bus_nb.rd1, vecs[k].e_nb_rd1);
            chk($sformatf("v%0d_nb_busy1", k), 32'(bus_nb.busy1), 32'(vecs[k].e_nb_busy1));
            chk($sformatf("v%0d_ready", k), 32'(bus.ready), 32'd1);
            $display("vec %0d: rd1=%h rd2=%h rd3=%h busy=%b nb_rd1=%h nb_busy1=%b", k,
                     bus.rd1, bus.rd2, bus.rd3, {bus.busy1, bus.busy2, bus.busy3},
                     bus_nb.rd1, bus_nb.busy1);
            @(negedge clk);
        end

        // r2 holds its value, r7 goes pending, then a reset mid-clear restarts the clear.
        idle_inputs();
        bus.ra1    = 4'd2;
        bus.sb_set = 1'b1;
        bus.sb_wa  = 4'd7;
        #1;
        chk("t5_r2_before", bus.rd1, 32'h1234);
        $display("t5 pre: r2=%h", bus.rd1);
        @(negedge clk);
        bus.sb_set = 1'b0;
        bus.ra1    = 4'd7;
        #1;
        chk("t5_busy7_before", 32'(bus.busy1), 32'd1);
        $display("t5 pre: busy r7=%b", bus.busy1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 7; i++) begin
            #1;
            chk($sformatf("t5_partial_ready_c%0d", i), 32'(bus.ready), 32'd0);
            $display("t5 partial clear cycle %0d: ready=%0d", i, bus.ready);
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        clear_check("t5");
        @(negedge clk);
        readback_zero("t5");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
